// File: rtl/vga_pat_sched.sv
// -----------------------------------------------------------------------------
// vga_pat_sched
//
// Frame-synchronous selector that chooses which of four RGB565 pattern sources
// feeds the pixel path in front of the VGA controller / HDMI encoder. Pattern
// changes only take effect on a frame boundary. They are requested by a key
// pulse or by an auto-advance frame timer. An optional run of all-BLACK frames
// is inserted between the old and the new pattern.
//
// Ports
//   vga_clk    in   1   pixel clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   pix_x      in  10   active x, 10'h3ff outside the active window
//   pix_y      in  10   active y, 10'h3ff outside the active window
//   key_next   in   1   single-cycle advance request (already debounced)
//   auto_en    in   1   level, enables timed auto-advance
//   src_data0  in  16   RGB565 from source 0
//   src_data1  in  16   RGB565 from source 1
//   src_data2  in  16   RGB565 from source 2
//   src_data3  in  16   RGB565 from source 3
//   pix_data   out 16   registered selected pixel (1-cycle latency)
//   pat_sel    out  2   index of the pattern currently displayed
//   busy       out  1   high while a switch is pending or blanking
//   sw_pulse   out  1   one-cycle pulse when a new pattern becomes visible
// -----------------------------------------------------------------------------
module vga_pat_sched #(
  parameter logic [9:0]  H_VALID      = 10'd640,
  parameter logic [9:0]  V_VALID      = 10'd480,
  parameter logic [2:0]  NUM_PAT      = 3'd4,
  parameter logic [7:0]  AUTO_FRAMES  = 8'd120,
  parameter logic [3:0]  BLANK_FRAMES = 4'd2,
  parameter logic [15:0] BLACK        = 16'h0000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        key_next,
  input  logic        auto_en,
  input  logic [15:0] src_data0,
  input  logic [15:0] src_data1,
  input  logic [15:0] src_data2,
  input  logic [15:0] src_data3,
  output logic [15:0] pix_data,
  output logic [1:0]  pat_sel,
  output logic        busy,
  output logic        sw_pulse
);

  // Only four sources exist; a larger request is clamped, zero behaves as one.
  localparam logic [2:0] NumPatC   = (NUM_PAT > 3'd4) ? 3'd4 :
                                     (NUM_PAT == 3'd0) ? 3'd1 : NUM_PAT;
  localparam logic [1:0] LastPat   = 2'(NumPatC - 3'd1);
  localparam logic [9:0] XLast     = H_VALID - 10'd1;
  localparam logic [9:0] YLast     = V_VALID - 10'd1;
  localparam logic [7:0] FrameLast = AUTO_FRAMES - 8'd1;
  localparam logic [3:0] BlankLast = BLANK_FRAMES - 4'd1;
  localparam bit         NoBlank   = (BLANK_FRAMES == 4'd0);
  localparam logic [9:0] OutOfWin  = 10'h3ff;

  typedef enum logic [1:0] {
    StShow,
    StPend,
    StBlank
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  pat_sel_q, pat_sel_d;
  logic [1:0]  pat_nxt_q, pat_nxt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]  blank_cnt_q, blank_cnt_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        busy_q, busy_d;
  logic        sw_pulse_q, sw_pulse_d;

  logic        frame_end;
  logic        auto_hit;
  logic        do_switch;
  logic [1:0]  nxt_idx;
  logic [15:0] src_sel;

  // Last active pixel of the frame; the raster source guarantees one cycle.
  assign frame_end = (pix_x == XLast) && (pix_y == YLast);

  assign auto_hit = auto_en && (state_q == StShow) && frame_end &&
                    (frame_cnt_q == FrameLast);

  assign nxt_idx = (pat_sel_q == LastPat) ? 2'd0 : pat_sel_q + 2'd1;

  always_comb begin
    src_sel = src_data0;
    unique case (pat_sel_q)
      2'd0:    src_sel = src_data0;
      2'd1:    src_sel = src_data1;
      2'd2:    src_sel = src_data2;
      2'd3:    src_sel = src_data3;
      default: src_sel = src_data0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pat_sel_d   = pat_sel_q;
    pat_nxt_d   = pat_nxt_q;
    frame_cnt_d = frame_cnt_q;
    blank_cnt_d = blank_cnt_q;
    sw_pulse_d  = 1'b0;
    do_switch   = 1'b0;

    unique case (state_q)
      StShow: begin
        // A key on the frame_end cycle itself switches right away, and merges
        // with a coincident auto request into a single advance.
        if (frame_end && (key_next || auto_hit)) begin
          do_switch = 1'b1;
        end else if (key_next) begin
          state_d = StPend;
        end else if (frame_end && (frame_cnt_q < FrameLast)) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      StPend: begin
        // Extra key pulses while pending are dropped, not queued.
        if (frame_end) begin
          do_switch = 1'b1;
        end
      end
      StBlank: begin
        if (frame_end) begin
          if (blank_cnt_q == BlankLast) begin
            pat_sel_d  = pat_nxt_q;
            sw_pulse_d = 1'b1;
            state_d    = StShow;
          end else begin
            blank_cnt_d = blank_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StShow;
      end
    endcase

    if (do_switch) begin
      frame_cnt_d = 8'd0;
      if (NoBlank) begin
        pat_sel_d  = nxt_idx;
        sw_pulse_d = 1'b1;
        state_d    = StShow;
      end else begin
        // The displayed index stays put until blanking has finished.
        pat_nxt_d   = nxt_idx;
        blank_cnt_d = 4'd0;
        state_d     = StBlank;
      end
    end

    // Dropping auto_en, even for one cycle, restarts the frame timer.
    if (!auto_en) begin
      frame_cnt_d = 8'd0;
    end

    busy_d = (state_d != StShow);

    // Uses the current state, so the frame_end pixel that starts blanking still
    // shows the old pattern and the one that ends blanking is still black.
    if ((pix_x == OutOfWin) || (pix_y == OutOfWin) || (state_q == StBlank)) begin
      pix_data_d = BLACK;
    end else begin
      pix_data_d = src_sel;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StShow;
      pat_sel_q   <= 2'd0;
      pat_nxt_q   <= 2'd0;
      frame_cnt_q <= 8'd0;
      blank_cnt_q <= 4'd0;
      pix_data_q  <= BLACK;
      busy_q      <= 1'b0;
      sw_pulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_sel_q   <= pat_sel_d;
      pat_nxt_q   <= pat_nxt_d;
      frame_cnt_q <= frame_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      pix_data_q  <= pix_data_d;
      busy_q      <= busy_d;
      sw_pulse_q  <= sw_pulse_d;
    end
  end

  assign pix_data = pix_data_q;
  assign pat_sel  = pat_sel_q;
  assign busy     = busy_q;
  assign sw_pulse = sw_pulse_q;

endmodule

// File: tb/tb_vga_pat_sched.sv
// -----------------------------------------------------------------------------
// tb_vga_pat_sched
//
// Three instances share one stimulus stream:
//   u_a : NUM_PAT=4, BLANK_FRAMES=2, AUTO_FRAMES=3
//   u_b : NUM_PAT=3, BLANK_FRAMES=1, AUTO_FRAMES=3
//   u_c : NUM_PAT=4, BLANK_FRAMES=0, AUTO_FRAMES=3
// A behavioural model predicts every registered output when inputs are driven;
// predictions are queued and compared one clock later. Fixed expectations from
// the intended behaviour are checked on top of that.
// -----------------------------------------------------------------------------
module tb_vga_pat_sched;

  localparam int MShow  = 0;
  localparam int MPend  = 1;
  localparam int MBlank = 2;
  localparam int Af     = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic        key_next, auto_en;
  logic [15:0] src [4];

  logic [15:0] pix_o [3];
  logic [1:0]  pat_o [3];
  logic        busy_o [3];
  logic        swp_o [3];

  always #5 clk = ~clk;

  vga_pat_sched #(.NUM_PAT(3'd4), .AUTO_FRAMES(8'd3), .BLANK_FRAMES(4'd2)) u_a (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .key_next(key_next), .auto_en(auto_en),
    .src_data0(src[0]), .src_data1(src[1]), .src_data2(src[2]), .src_data3(src[3]),
    .pix_data(pix_o[0]), .pat_sel(pat_o[0]), .busy(busy_o[0]), .sw_pulse(swp_o[0])
  );

  vga_pat_sched #(.NUM_PAT(3'd3), .AUTO_FRAMES(8'd3), .BLANK_FRAMES(4'd1)) u_b (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .key_next(key_next), .auto_en(auto_en),
    .src_data0(src[0]), .src_data1(src[1]), .src_data2(src[2]), .src_data3(src[3]),
    .pix_data(pix_o[1]), .pat_sel(pat_o[1]), .busy(busy_o[1]), .sw_pulse(swp_o[1])
  );

  vga_pat_sched #(.NUM_PAT(3'd4), .AUTO_FRAMES(8'd3), .BLANK_FRAMES(4'd0)) u_c (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .key_next(key_next), .auto_en(auto_en),
    .src_data0(src[0]), .src_data1(src[1]), .src_data2(src[2]), .src_data3(src[3]),
    .pix_data(pix_o[2]), .pat_sel(pat_o[2]), .busy(busy_o[2]), .sw_pulse(swp_o[2])
  );

  typedef struct packed {
    logic [2:0][15:0] pix;
    logic [2:0][1:0]  pat;
    logic [2:0]       busy;
    logic [2:0]       swp;
  } exp_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] src0;
    logic [15:0] exp_pix;
  } vec_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;
  int   swcnt [3];

  int   m_st [3];
  int   m_pat [3];
  int   m_nxt [3];
  int   m_fc [3];
  int   m_bc [3];
  int   np [3];
  int   bf [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i]  = MShow;
      m_pat[i] = 0;
      m_nxt[i] = 0;
      m_fc[i]  = 0;
      m_bc[i]  = 0;
    end
    exp_q.delete();
  endtask

  // Predict the outputs that appear after the next rising edge.
  task automatic model_step();
    exp_t e;
    bit   fe, sw, vis, ahit;
    int   n;
    fe = (pix_x == 10'd639) && (pix_y == 10'd479);
    for (int i = 0; i < 3; i++) begin
      if (pix_x == 10'h3ff || pix_y == 10'h3ff || m_st[i] == MBlank) e.pix[i] = 16'h0000;
      else e.pix[i] = src[m_pat[i]];
      sw   = 1'b0;
      vis  = 1'b0;
      ahit = auto_en && (m_st[i] == MShow) && fe && (m_fc[i] == Af - 1);
      if (m_st[i] == MShow) begin
        if (fe && (key_next || ahit)) sw = 1'b1;
        else if (key_next) m_st[i] = MPend;
        else if (fe && m_fc[i] < Af - 1) m_fc[i]++;
      end else if (m_st[i] == MPend) begin
        if (fe) sw = 1'b1;
      end else if (fe) begin
        if (m_bc[i] == bf[i] - 1) begin
          m_pat[i] = m_nxt[i];
          m_st[i]  = MShow;
          vis      = 1'b1;
        end else begin
          m_bc[i]++;
        end
      end
      if (sw) begin
        n = (m_pat[i] == np[i] - 1) ? 0 : m_pat[i] + 1;
        m_fc[i] = 0;
        if (bf[i] == 0) begin
          m_pat[i] = n;
          m_st[i]  = MShow;
          vis      = 1'b1;
        end else begin
          m_nxt[i] = n;
          m_bc[i]  = 0;
          m_st[i]  = MBlank;
        end
      end
      if (!auto_en) m_fc[i] = 0;
      e.pat[i]  = 2'(m_pat[i]);
      e.busy[i] = (m_st[i] != MShow);
      e.swp[i]  = vis;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic key);
    exp_t got;
    pix_x    = x;
    pix_y    = y;
    key_next = key;
    model_step();
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pix[%0d]", i), 32'(pix_o[i]), 32'(got.pix[i]));
      chk($sformatf("pat_sel[%0d]", i), 32'(pat_o[i]), 32'(got.pat[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(got.busy[i]));
      chk($sformatf("sw_pulse[%0d]", i), 32'(swp_o[i]), 32'(got.swp[i]));
      swcnt[i] += int'(swp_o[i]);
    end
    key_next = 1'b0;
  endtask

  // Six-cycle abstract frame: blanking, four active pixels, then frame_end.
  task automatic run_frame(input logic [5:0] kmask, input int drop);
    logic [9:0] x, y;
    logic       save;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        x = 10'h3ff;
        y = 10'h3ff;
      end else if (c == 5) begin
        x = 10'd639;
        y = 10'd479;
      end else begin
        x = 10'(c * 7);
        y = 10'(c + 10);
      end
      save = auto_en;
      if (c == drop) auto_en = 1'b0;
      step(x, y, kmask[c]);
      auto_en = save;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_pix[%0d]", tag, i), 32'(pix_o[i]), 32'h0);
      chk($sformatf("%s_pat[%0d]", tag, i), 32'(pat_o[i]), 32'h0);
      chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy_o[i]), 32'h0);
      chk($sformatf("%s_swp[%0d]", tag, i), 32'(swp_o[i]), 32'h0);
    end
  endtask

  task automatic clr_swcnt();
    for (int i = 0; i < 3; i++) swcnt[i] = 0;
  endtask

  initial begin
    vec_t vt [7];
    vt[0] = '{x: 10'd5,   y: 10'd5,   src0: 16'hF800, exp_pix: 16'hF800};
    vt[1] = '{x: 10'h3ff, y: 10'd5,   src0: 16'h1234, exp_pix: 16'h0000};
    vt[2] = '{x: 10'd5,   y: 10'h3ff, src0: 16'h1234, exp_pix: 16'h0000};
    vt[3] = '{x: 10'd0,   y: 10'd0,   src0: 16'h1234, exp_pix: 16'h1234};
    vt[4] = '{x: 10'd639, y: 10'd0,   src0: 16'hABCD, exp_pix: 16'hABCD};
    vt[5] = '{x: 10'h3ff, y: 10'h3ff, src0: 16'hFFFF, exp_pix: 16'h0000};
    vt[6] = '{x: 10'd0,   y: 10'd479, src0: 16'h5A5A, exp_pix: 16'h5A5A};

    np = '{4, 3, 4};
    bf = '{2, 1, 0};
    src[0] = 16'hF800;
    src[1] = 16'h07E0;
    src[2] = 16'h001F;
    src[3] = 16'hFFFF;
    key_next = 1'b0;
    auto_en  = 1'b0;
    pix_x    = 10'd5;
    pix_y    = 10'd5;
    clr_swcnt();

    // Reset holds BLACK even with an in-window pixel and red on source 0.
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    #3 rst_n = 1'b1;
    step(10'd5, 10'd5, 1'b0);
    chk("rst_release_pix", 32'(pix_o[0]), 32'hF800);

    // Pixel path through the vector table.
    for (int k = 0; k < 7; k++) begin
      src[0] = vt[k].src0;
      step(vt[k].x, vt[k].y, 1'b0);
      chk($sformatf("tbl_pix[%0d]", k), 32'(pix_o[0]), 32'(vt[k].exp_pix));
    end
    src[0] = 16'hF800;

    // Key advance mid-frame with extra pulses during PEND and BLANK.
    clr_swcnt();
    run_frame(6'b001100, -1);
    run_frame(6'b000100, -1);
    run_frame(6'b000000, -1);
    chk("key_pat_a", 32'(pat_o[0]), 32'd1);
    chk("key_pat_b", 32'(pat_o[1]), 32'd1);
    chk("key_pat_c", 32'(pat_o[2]), 32'd2);
    chk("key_swcnt_a", 32'(swcnt[0]), 32'd1);
    chk("key_swcnt_b", 32'(swcnt[1]), 32'd1);
    chk("key_swcnt_c", 32'(swcnt[2]), 32'd2);
    step(10'd5, 10'd5, 1'b0);
    chk("key_pix_a", 32'(pix_o[0]), 32'h07E0);
    chk("key_pix_c", 32'(pix_o[2]), 32'h001F);

    // Two more advances: B (three patterns) and C wrap back to 0.
    for (int r = 0; r < 2; r++) begin
      run_frame(6'b000100, -1);
      run_frame(6'b000000, -1);
      run_frame(6'b000000, -1);
    end
    chk("wrap_pat_a", 32'(pat_o[0]), 32'd3);
    chk("wrap_pat_b", 32'(pat_o[1]), 32'd0);
    chk("wrap_pat_c", 32'(pat_o[2]), 32'd0);

    // Key exactly on frame_end switches at that frame_end.
    run_frame(6'b100000, -1);
    chk("fe_key_pat_c", 32'(pat_o[2]), 32'd1);
    chk("fe_key_busy_c", 32'(busy_o[2]), 32'd0);
    chk("fe_key_busy_a", 32'(busy_o[0]), 32'd1);
    run_frame(6'b000000, -1);
    run_frame(6'b000000, -1);
    chk("fe_key_pat_a", 32'(pat_o[0]), 32'd0);
    chk("fe_key_pat_b", 32'(pat_o[1]), 32'd1);

    // Auto mode: C advances every three frame_ends.
    auto_en = 1'b1;
    for (int f = 0; f < 6; f++) run_frame(6'b000000, -1);
    chk("auto_pat_c6", 32'(pat_o[2]), 32'd3);
    run_frame(6'b000000, -1);
    run_frame(6'b000000, -1);
    run_frame(6'b000000, 2);
    chk("auto_drop_c9", 32'(pat_o[2]), 32'd3);
    run_frame(6'b000000, -1);
    chk("auto_drop_c10", 32'(pat_o[2]), 32'd3);
    run_frame(6'b000000, -1);
    chk("auto_drop_c11", 32'(pat_o[2]), 32'd0);

    // Key coincident with the auto-triggering frame_end: a single advance.
    run_frame(6'b000000, -1);
    run_frame(6'b000000, -1);
    clr_swcnt();
    run_frame(6'b100000, -1);
    chk("coinc_pat_c", 32'(pat_o[2]), 32'd1);
    chk("coinc_swcnt_c", 32'(swcnt[2]), 32'd1);

    // Reset while A and B are blanking.
    auto_en = 1'b0;
    for (int f = 0; f < 3; f++) run_frame(6'b000000, -1);
    run_frame(6'b100000, -1);
    step(10'd3, 10'd3, 1'b0);
    chk("preblank_busy_a", 32'(busy_o[0]), 32'd1);
    chk("preblank_pix_a", 32'(pix_o[0]), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("midrst_hold");
    #3 rst_n = 1'b1;
    clr_swcnt();
    for (int f = 0; f < 3; f++) run_frame(6'b000000, -1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("postrst_swcnt[%0d]", i), 32'(swcnt[i]), 32'd0);
      chk($sformatf("postrst_pat[%0d]", i), 32'(pat_o[i]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pat_sched.md
Name: vga_pat_sched

Overview:
- Frame-synchronous scheduler that sequences which of four pixel pattern sources drives the VGA/HDMI pixel path.
- Sources: colour bar, grid, solid, ramp, or any other 16-bit RGB565 generators.
- Sits between the pattern generators and the vga_ctrl/HDMI encoder pixel input.
- Pattern changes happen only on frame boundaries, on request from a key pulse or an auto-advance timer. A black blanking interval is inserted between patterns.

Parameters:
- H_VALID, 10'd640: active pixels per line.
- V_VALID, 10'd480: active lines per frame.
- NUM_PAT, 3'd4: number of sources in use, 1..4. Pattern index wraps at NUM_PAT-1.
- AUTO_FRAMES, 8'd120: frames shown per pattern in auto mode.
- BLANK_FRAMES, 4'd2: frames of BLACK inserted on each switch. 0 means no blanking.
- BLACK, 16'h0000: blanking/out-of-window colour.

Ports:
- vga_clk  in  1  pixel clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- pix_x  in  10  current active x. 10'h3ff when outside the active window.
- pix_y  in  10  current active y. 10'h3ff when outside the active window.
- key_next  in  1  single-cycle advance request, already debounced.
- auto_en  in  1  level. 1 enables timed auto-advance.
- src_data0  in  16  RGB565 from source 0.
- src_data1  in  16  RGB565 from source 1.
- src_data2  in  16  RGB565 from source 2.
- src_data3  in  16  RGB565 from source 3.
- pix_data  out  16  registered selected pixel.
- pat_sel  out  2  index of the pattern currently displayed.
- busy  out  1  high in PEND or BLANK.
- sw_pulse  out  1  one-cycle pulse when a new pattern becomes visible.

Behaviour:
- Clocking and reset: one clock, vga_clk. Reset is asynchronous, active-low on sys_rst_n. All state is cleared on reset assertion at any time, including mid-blank.
- Reset values: pix_data=BLACK, pat_sel=0, busy=0, sw_pulse=0, state=SHOW, frame_cnt=0, blank_cnt=0.
- frame_end (internal, combinational): pix_x==H_VALID-1 && pix_y==V_VALID-1. It is true for exactly one cycle per frame.
- adv_req (internal): key_next, OR (auto_en && state==SHOW && frame_end && frame_cnt==AUTO_FRAMES-1).
- frame_cnt (8 bit):
  - Increments on frame_end in SHOW.
  - Cleared on any pattern switch, and whenever auto_en==0.
  - Saturates at AUTO_FRAMES-1 (no wrap).
- State SHOW:
  - key_next alone -> PEND.
  - Auto adv_req (which occurs at frame_end) switches at that same frame_end, without passing through PEND.
  - key_next in the same cycle as frame_end is treated as a switch at this frame_end.
- State PEND: waits for the next frame_end, then performs the switch. Further key_next pulses are ignored; there is no queueing.
- Switch action:
  - nxt = (pat_sel==NUM_PAT-1) ? 0 : pat_sel+1.
  - If BLANK_FRAMES==0: pat_sel<=nxt, go to SHOW, pulse sw_pulse.
  - Otherwise: hold nxt internally, blank_cnt<=0, go to BLANK. pat_sel is unchanged until blanking ends.
- State BLANK:
  - pix_data forced to BLACK.
  - blank_cnt increments on each frame_end.
  - On the frame_end where blank_cnt==BLANK_FRAMES-1: pat_sel<=nxt, sw_pulse=1 for the next cycle, go to SHOW.
  - key_next and auto requests are ignored.
- NUM_PAT==1: a switch reloads index 0. Blanking still occurs.
- pix_data (1-cycle latency from pix_x/pix_y/src_data):
  - BLACK when pix_x==10'h3ff or pix_y==10'h3ff, or state==BLANK.
  - Otherwise src_data[pat_sel] sampled this cycle.
  - The SHOW->BLANK transition at frame_end does not blank the frame_end pixel itself. Its registered output is the last pixel of the old pattern.
- busy: registered, equal to (state!=SHOW).
- Out-of-range pat_sel cannot occur. If NUM_PAT>4, it is clamped to 4 at elaboration.

Test Plan:
- Reset: hold sys_rst_n=0 with src_data0=16'hF800 -> pix_data=0000, pat_sel=0, busy=0. Release, apply pix_x=5, pix_y=5 -> pix_data=F800 one cycle later.
- Key advance, BLANK_FRAMES=2: pulse key_next mid-frame -> busy=1 next cycle, pat_sel=0 until frame_end. Two full frames of pix_data=0000 follow. Then sw_pulse for 1 cycle, pat_sel=1, pix_data=src_data1.
- Wrap: NUM_PAT=3, pat_sel=2, key advance -> pat_sel=0 after blanking. Extra key_next pulses during PEND/BLANK -> only one advance.
- Auto mode: AUTO_FRAMES=3, BLANK_FRAMES=0, auto_en=1 -> pat_sel changes 0->1->2->3->0 every 3 frame_ends. Deasserting auto_en for one cycle restarts the count.
- Simultaneous events: key_next coincident with the auto-triggering frame_end -> exactly one increment. key_next exactly on frame_end in SHOW -> switch at that frame_end with no PEND state.
- Reset mid-BLANK: assert sys_rst_n=0 during BLANK -> immediate pat_sel=0, busy=0, pix_data=0000. No sw_pulse after release.
